bcd_display_driver: RTL and testbench
=====================================

# bcd_display_driver

Parametrised successor to the two-digit press-count display. Converts an unsigned binary value of configurable width into DIGITS decimal digits using a sequential double-dabble converter, one input bit per cycle. Drives active-low 7-segment patterns for each digit and flags values that do not fit. Sits between any counter or statistic register and the board HEX outputs.

## Interface
- WIDTH, 7: bit width of the binary input; must be ≥ 1.
- DIGITS, 2: number of decimal digits driven; must be ≥ 1.
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous, active-low reset.
- valid_in  in  1  request to convert `value`.
- value  in  WIDTH  unsigned binary input, sampled on accept.
- ready  out  1  high when idle; accept occurs when `valid_in && ready` at a rising edge.
- done  out  1  one-cycle pulse in the cycle when `hex` and `overflow` are updated.
- overflow  out  1  latched high when the last accepted value is ≥ 10^DIGITS.
- hex  out  7*DIGITS  segment patterns, active-low, bit order g..a; digit i is at [7i+6:7i], and digit 0 is the units digit.

## Operation
- FSM states: IDLE, SHIFT, LATCH.
  - IDLE: `ready`=1. On accept, load `value` into the shift register, clear the BCD register and the overflow accumulator, set bit counter = WIDTH, and go to SHIFT.
  - SHIFT: `ready`=0. Each cycle:
    - Add 3 to every BCD nibble that is ≥ 5.
    - Shift {BCD, binary} left by one.
    - OR the bit shifted out of the top nibble into the overflow accumulator.
    - Decrement the counter. When it reaches 0, go to LATCH.
  - LATCH: update `hex` and `overflow`, pulse `done`, return to IDLE.
- Decode rule: digits 0–9 map to the standard active-low patterns (0 = 1000000 … 9 = 0010000). Any unreachable nibble maps to blank (1111111).
- Overflow: if the accumulator is set, every digit shows a dash (0111111) and `overflow`=1. Otherwise `overflow`=0.
- Outputs hold their value between conversions. `valid_in` is ignored while `ready`=0; there is no queuing.
- Reset (asynchronous, at any time, including mid-conversion): state = IDLE, `ready`=1, `done`=0, `overflow`=0, `hex` = display of value 0 (see Configuration). Any partial conversion is discarded.

## Timing
- Accept at edge k. SHIFT occupies edges k+1 … k+WIDTH. LATCH happens at edge k+WIDTH+1, where `hex`/`overflow` update and `done` is high for that one cycle.
- `ready` returns high in the cycle after LATCH. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Zero digits above the most significant non-zero digit show blank (1111111).
  - Digit 0 is always shown.
  - Reset display: digit 0 = 0, all others blank.
  - Dashes on overflow are unaffected.
- LEADING_ZERO_BLANK_EN undefined: all digits are shown, including leading zeros, and the reset display is all 0s.

## Structure
- Shared package display_pkg holds:
  - Segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - The FSM state typedef.
  - A function giving BCD width = 4*DIGITS.
- Sub-module seg7_decoder: 4-bit BCD in, 7-bit active-low pattern out, combinational. Instantiate it DIGITS times via generate, feeding the registered `hex` stage.

## Test plan
- WIDTH=7, DIGITS=2. Accept 42. Required: `done` exactly 8 cycles after accept; hex[6:0]=0100100, hex[13:7]=0011001, `overflow`=0.
- Accept 100, then 127. Required: both show hex=0111111_0111111 and `overflow`=1. A following accept of 99 clears `overflow` and shows 0010000_0010000.
- Accept 5 with LEADING_ZERO_BLANK_EN defined. Required: hex[13:7]=1111111, hex[6:0]=0010010. With the macro undefined: hex[13:7]=1000000.
- Hold `valid_in`=1 continuously with `value` changing every cycle. Required: only values sampled while `ready`=1 are converted, and `done` occurs every 9 cycles.
- Assert `clrn`=0 at cycle 3 of a conversion of 77. Required: immediate reset display, `ready`=1, no `done` pulse, and the next accept of 13 converts correctly.
- WIDTH=14, DIGITS=4. Accept 9999. Required: all digits show 0010000, no overflow, latency 15 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - segment constants, FSM state type and BCD sizing helper for bcd_display_driver
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD nibble to active-low 7-segment pattern (g..a)
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - sequential double-dabble binary to multi-digit 7-segment driver
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  valid_in,
  input  logic [WIDTH-1:0]      value,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int BW = bcd_width(DIGITS);
  localparam int CW = $clog2(WIDTH + 1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     bin_q;
  logic [BW-1:0]        bcd_q, bcd_adj;
  logic                 ovf_acc;
  logic [CW-1:0]        cnt;
  logic [7*DIGITS-1:0]  seg_raw, hex_nxt, hex_rst;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid_in) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: if (cnt == CW'(1)) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd (bcd_q[4*g +: 4]),
      .seg (seg_raw[7*g +: 7])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lead_zero;

  // lead_zero[i]: digit i and everything above it are zero
  always_comb begin
    logic z;
    z = 1'b1;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (bcd_q[4*i +: 4] == 4'd0);
      lead_zero[i] = z;
    end
  end

  always_comb begin
    hex_nxt = seg_raw;
    hex_rst = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex_rst[7*i +: 7] = (i == 0) ? SEG_0 : SEG_BLANK;
      if (ovf_acc) hex_nxt[7*i +: 7] = SEG_DASH;
      else if (i != 0 && lead_zero[i]) hex_nxt[7*i +: 7] = SEG_BLANK;
    end
  end
`else
  always_comb begin
    hex_nxt = seg_raw;
    hex_rst = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex_rst[7*i +: 7] = SEG_0;
      if (ovf_acc) hex_nxt[7*i +: 7] = SEG_DASH;
    end
  end
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      hex      <= hex_rst;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        ST_IDLE: if (valid_in) begin
          bin_q   <= value;
          bcd_q   <= '0;
          ovf_acc <= 1'b0;
          cnt     <= CW'(WIDTH);
        end
        ST_SHIFT: begin
          // carry out of the top nibble means the value needs another digit
          bcd_q   <= {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
          bin_q   <= bin_q << 1;
          ovf_acc <= ovf_acc | bcd_adj[BW-1];
          cnt     <= cnt - CW'(1);
        end
        ST_LATCH: begin
          hex      <= hex_nxt;
          overflow <= ovf_acc;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - self-checking bench for bcd_display_driver (2-digit and 4-digit instances)
module tb_bcd_display_driver;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk, clrn;
  logic        valid_a, valid_b;
  logic [6:0]  value_a;
  logic [13:0] value_b;
  logic        ready_a, done_a, ovf_a, ready_b, done_b, ovf_b;
  logic [13:0] hex_a;
  logic [27:0] hex_b;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  bcd_display_driver #(.WIDTH(7), .DIGITS(2)) u_dut_a (
    .clk(clk), .clrn(clrn), .valid_in(valid_a), .value(value_a),
    .ready(ready_a), .done(done_a), .overflow(ovf_a), .hex(hex_a)
  );

  bcd_display_driver #(.WIDTH(14), .DIGITS(4)) u_dut_b (
    .clk(clk), .clrn(clrn), .valid_in(valid_b), .value(value_b),
    .ready(ready_b), .done(done_b), .overflow(ovf_b), .hex(hex_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] disp(input int v, input int d);
    logic [27:0] r = '0;
    for (int i = 0; i < d; i++) begin
      if (v >= pow10(d)) r[7*i +: 7] = 7'b0111111;
      else if (LZB && i > 0 && v < pow10(i)) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = seg((v / pow10(i)) % 10);
    end
    return r;
  endfunction

  // Reference model: a busy countdown per instance; result appears WIDTH+1 edges after accept
  int          m_left[2];
  int          m_pend[2];
  logic        m_done[2];
  logic        m_ovf[2];
  logic [27:0] m_hex[2];

  always @(posedge clk or negedge clrn) begin
    for (int j = 0; j < 2; j++) begin
      if (!clrn) begin
        m_left[j] <= 0;
        m_done[j] <= 1'b0;
        m_ovf[j]  <= 1'b0;
        m_hex[j]  <= disp(0, (j == 0) ? 2 : 4);
      end else begin
        m_done[j] <= 1'b0;
        if (m_left[j] > 0) begin
          m_left[j] <= m_left[j] - 1;
          if (m_left[j] == 1) begin
            m_done[j] <= 1'b1;
            m_hex[j]  <= disp(m_pend[j], (j == 0) ? 2 : 4);
            m_ovf[j]  <= (m_pend[j] >= pow10((j == 0) ? 2 : 4));
          end
        end else if ((j == 0) ? valid_a : valid_b) begin
          m_left[j] <= ((j == 0) ? 7 : 14) + 1;
          m_pend[j] <= (j == 0) ? int'(value_a) : int'(value_b);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ready", 32'(ready_a), 32'(m_left[0] == 0));
      check("a_done",  32'(done_a),  32'(m_done[0]));
      check("a_ovf",   32'(ovf_a),   32'(m_ovf[0]));
      check("a_hex",   32'(hex_a),   32'(m_hex[0]));
      check("b_ready", 32'(ready_b), 32'(m_left[1] == 0));
      check("b_done",  32'(done_b),  32'(m_done[1]));
      check("b_ovf",   32'(ovf_b),   32'(m_ovf[1]));
      check("b_hex",   32'(hex_b),   32'(m_hex[1]));
    end
  end

  // Starts #1 after a rising edge with the instance idle; lat = edges from accept to done
  task automatic convert(input int j, input int v, output int lat);
    if (j == 0) begin valid_a = 1'b1; value_a = 7'(v); end
    else begin valid_b = 1'b1; value_b = 14'(v); end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if ((j == 0) ? done_a : done_b) begin
        lat = n;
        break;
      end
    end
  endtask

  logic [13:0] rst_a;
  int lat, last_done, ndone, seen;

  initial begin
    rst_a = LZB ? 14'b1111111_1000000 : 14'b1000000_1000000;
    clrn = 1'b0; valid_a = 1'b0; valid_b = 1'b0; value_a = '0; value_b = '0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    chk_en = 1'b1;
    check("rst_hex", 32'(hex_a), 32'(rst_a));
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_ovf", 32'(ovf_a), 32'd0);

    convert(0, 42, lat);
    check("lat42", 32'(lat), 32'd8);
    check("hex42", 32'(hex_a), 32'(14'b0011001_0100100));
    check("ovf42", 32'(ovf_a), 32'd0);

    convert(0, 100, lat);
    check("hex100", 32'(hex_a), 32'(14'b0111111_0111111));
    check("ovf100", 32'(ovf_a), 32'd1);
    convert(0, 127, lat);
    check("hex127", 32'(hex_a), 32'(14'b0111111_0111111));
    check("ovf127", 32'(ovf_a), 32'd1);
    convert(0, 99, lat);
    check("hex99", 32'(hex_a), 32'(14'b0010000_0010000));
    check("ovf99", 32'(ovf_a), 32'd0);

    convert(0, 5, lat);
    check("hex5_hi", 32'(hex_a[13:7]), LZB ? 32'(7'b1111111) : 32'(7'b1000000));
    check("hex5_lo", 32'(hex_a[6:0]), 32'(7'b0010010));

    // valid held high with a new value every cycle
    valid_a = 1'b1; value_a = 7'd11;
    last_done = -1; ndone = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done_a) begin
        if (last_done >= 0) check("period", 32'(c - last_done), 32'd9);
        last_done = c;
        ndone++;
      end
      value_a = value_a + 7'd13;
    end
    valid_a = 1'b0;
    check("ndone", 32'(ndone), 32'd5);

    // reset in the middle of converting 77
    valid_a = 1'b1; value_a = 7'd77;
    @(posedge clk); #1 valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #2 clrn = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready_a), 32'd1);
    check("mid_rst_hex", 32'(hex_a), 32'(rst_a));
    check("mid_rst_done", 32'(done_a), 32'd0);
    @(posedge clk); #1 clrn = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done_a) seen++;
    end
    check("no_done_after_rst", 32'(seen), 32'd0);
    convert(0, 13, lat);
    check("lat13", 32'(lat), 32'd8);
    check("hex13", 32'(hex_a), 32'(14'b1111001_0110000));

    convert(1, 9999, lat);
    check("lat9999", 32'(lat), 32'd15);
    check("hex9999", 32'(hex_b), 32'({4{7'b0010000}}));
    check("ovf9999", 32'(ovf_b), 32'd0);
    convert(1, 10000, lat);
    check("hex10000", 32'(hex_b), 32'({4{7'b0111111}}));
    check("ovf10000", 32'(ovf_b), 32'd1);
    convert(1, 7, lat);
    check("hex7_b", 32'(hex_b), LZB ? 32'({21'h1FFFFF, 7'b1111000})
                                    : 32'({{3{7'b1000000}}, 7'b1111000}));

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
